aidc_lite_code_packer: RTL
==========================

Name: aidc_lite_code_packer

Overview:
- Parametrised successor to the fixed 64-bit code concatenator. Packs MSB-aligned variable-length codes into OUT_W-bit words, one compressed block at a time. Each block starts with a configurable prefix.
- Adds a ready/valid handshake on both sides and an output FIFO with backpressure.
- On EOP, flushes the final word zero-padded, with an explicit last flag. Flags protocol errors.
- Sits between the per-word encoder and the compressed-block store.

Parameters:
- OUT_W, 64: output word width in bits; power of 2, 32..256.
- DATA_SIZE, 66: data_i width; codes are MSB-aligned in data_i.
- MAX_CODE, 64: largest legal size_i value; must satisfy MAX_CODE <= OUT_W.
- PREFIX_W, 2: prefix width in bits, 1..8.
- PREFIX, 0: prefix value, PREFIX_W bits.
- FIFO_DEPTH, 4: output FIFO entries; power of 2, >= 2.
- ADDR_W, 4: word-index width; one block holds at most 2^ADDR_W words.
- BLK_W, 11: width of the block bit-count.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- valid_i  in  1  input code valid
- ready_o  out  1  packer can accept a code
- sop_i  in  1  first code of a block
- eop_i  in  1  last code of a block
- data_i  in  DATA_SIZE  code, MSB-aligned
- size_i  in  $clog2(MAX_CODE+1)  code length in bits; 0 is legal
- valid_o  out  1  output word valid
- ready_i  in  1  downstream accepts the word
- data_o  out  OUT_W  packed word; earliest bit at the MSB
- addr_o  out  ADDR_W  word index within the block
- last_o  out  1  final word of the block
- blk_size_o  out  BLK_W  block bits including prefix, up to and including this word
- err_o  out  1  sticky protocol error

Behaviour:
- Reset is one clock with asynchronous active-low reset.
- State on reset assertion:
  - valid_o=0, ready_o=0 while reset is asserted; ready_o=1 from the first clock after release.
  - last_o=0, err_o=0, addr_o=0, blk_size_o=0, data_o=0.
  - FIFO emptied, FSM=ACC.
  - Accumulator fill=PREFIX_W, accumulator MSBs=PREFIX, rest zero. Word counter=0, bit counter=PREFIX_W.
- Input handshake:
  - A code is accepted when valid_i && ready_o.
  - ready_o = (FSM==ACC) && (FIFO not full). The full test uses the registered occupancy; a same-cycle pop is not credited.
- Accept, arithmetic:
  - Append the top size_i bits of data_i at accumulator offset fill, counted from the MSB.
  - Only the top size_i bits are used. Bits of data_i below the code are ignored and masked.
  - new = fill + size_i. fill < OUT_W holds before the add, so new <= 2*OUT_W-1.
- Accept, non-EOP:
  - If new >= OUT_W: push the top OUT_W bits with addr = word counter, last=0, blk_size = bits emitted so far in the block. Shift the remainder up; fill = new - OUT_W; increment the word counter.
  - Otherwise: fill = new, nothing pushed.
- Accept with eop_i:
  - If new <= OUT_W: push one word. Low OUT_W-new bits are zero. last=1, blk_size = total block bits.
  - If new > OUT_W: push the full word (last=0) this cycle. Enter FLUSH; ready_o=0.
  - FLUSH: when the FIFO is not full, push the zero-padded remainder with last=1, then return to ACC.
  - After the last word is pushed: reload the prefix state (fill=PREFIX_W), word counter=0, bit counter=PREFIX_W.
- Latency:
  - A word pushed in cycle N is presented on valid_o in cycle N+1 if the FIFO was empty.
  - A FLUSH remainder is presented no earlier than N+2.
- Output:
  - FIFO head drives data_o, addr_o, last_o, blk_size_o. Pop on valid_o && ready_i.
  - Outputs hold stable while valid_o && !ready_i.
- err_o sets and stays set until reset on any of:
  - sop_i accepted while word counter != 0 or fill != PREFIX_W (mid-block SOP). The code is still packed normally.
  - size_i > MAX_CODE. The code is dropped and state is unchanged.
  - Word counter wrap, i.e. a push with counter = 2^ADDR_W-1 and last=0. addr wraps to 0.
  - Bit counter overflow of BLK_W. The counter saturates at all-ones.
- Simultaneous push and pop in the same cycle: occupancy is unchanged.
- Reset asserted mid-block or in FLUSH: the partial block is discarded and the FIFO contents are lost.

Test Plan:
- Reset release -> valid_o=0, ready_o=1, err_o=0. An eop with size 0 gives one word: 0x0000_0000_0000_0000, last=1, blk_size=2, addr=0.
- sop, then sizes 6, 34, 34 (OUT_W=64, PREFIX=2'b00) -> no output after codes 1 and 2. After code 3: one word, addr=0, blk_size=64, last=0; residual fill=12.
- The above, with eop on a 4th code of size 34 (total 110) -> word addr=1 with blk_size=110, last=1, low 18 bits zero. Then next block's fill=2.
- eop on the 3rd code (total 76) -> word0 addr=0 blk=64, then ready_o=0 for one cycle, then word1 addr=1 last=1 blk=76 with low 52 bits zero.
- ready_i=0, FIFO_DEPTH=4, stream of size-64 codes -> ready_o drops after the 4th word push. Holding outputs stable, no loss. After ready_i=1, words pop in order, addr 0..3.
- sop mid-block -> err_o=1 stays set. size_i=MAX_CODE+1 -> code dropped. Async reset in FLUSH -> FIFO empty, blk_size restarts at 2.

Source files
------------

// File: rtl/aidc_lite_code_packer.sv
// Packs MSB-aligned variable-length codes into OUT_W-bit words, one block at a time.
// Each block starts with a fixed prefix; the final word is zero-padded and flagged last.
// Packed words are queued in a small output FIFO with ready/valid backpressure.
module aidc_lite_code_packer #(
    parameter int unsigned         OUT_W      = 64,
    parameter int unsigned         DATA_SIZE  = 66,
    parameter int unsigned         MAX_CODE   = 64,
    parameter int unsigned         PREFIX_W   = 2,
    parameter logic [PREFIX_W-1:0] PREFIX     = '0,
    parameter int unsigned         FIFO_DEPTH = 4,
    parameter int unsigned         ADDR_W     = 4,
    parameter int unsigned         BLK_W      = 11
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            valid_i,
    output logic                            ready_o,
    input  logic                            sop_i,
    input  logic                            eop_i,
    input  logic [DATA_SIZE-1:0]            data_i,
    input  logic [$clog2(MAX_CODE+1)-1:0]   size_i,
    output logic                            valid_o,
    input  logic                            ready_i,
    output logic [OUT_W-1:0]                data_o,
    output logic [ADDR_W-1:0]               addr_o,
    output logic                            last_o,
    output logic [BLK_W-1:0]                blk_size_o,
    output logic                            err_o
);

    localparam int unsigned SIZE_W = $clog2(MAX_CODE + 1);
    localparam int unsigned FILL_W = $clog2(2 * OUT_W);
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned ENT_W  = OUT_W + ADDR_W + 1 + BLK_W;

    localparam logic [OUT_W-1:0] ACC_INIT = {PREFIX, {(OUT_W - PREFIX_W){1'b0}}};

    typedef enum logic [0:0] {StAcc, StFlush} state_e;

    // Packer state
    state_e              state_q, state_d;
    logic [OUT_W-1:0]    acc_q, acc_d;
    logic [FILL_W-1:0]   fill_q, fill_d;
    logic [ADDR_W-1:0]   wcnt_q, wcnt_d;
    logic [BLK_W-1:0]    bcnt_q, bcnt_d;
    logic                err_q, err_d;
    logic                init_q;

    // FIFO state
    logic [ENT_W-1:0]    mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]    count_q;

    // Datapath
    logic [OUT_W-1:0]    code_top, code_mask, code_m;
    logic [2*OUT_W-1:0]  wide;
    logic [FILL_W-1:0]   new_fill, rem_fill;
    logic [BLK_W:0]      bsum;
    logic                bovf;
    logic [BLK_W-1:0]    bsat, emitted;

    logic                full, accept, pop, push, push_last;
    logic [OUT_W-1:0]    push_data;
    logic [ADDR_W-1:0]   push_addr;
    logic [BLK_W-1:0]    push_blk;

    // Take the top OUT_W bits of data_i as the candidate code
    if (DATA_SIZE >= OUT_W) begin : g_code_wide
        assign code_top = data_i[DATA_SIZE-1 -: OUT_W];
        if (DATA_SIZE > OUT_W) begin : g_low
            logic unused_low;
            assign unused_low = ^data_i[DATA_SIZE-OUT_W-1:0];
        end
    end else begin : g_code_narrow
        assign code_top = {data_i, {(OUT_W - DATA_SIZE){1'b0}}};
    end

    assign full    = (count_q == CNT_W'(FIFO_DEPTH));
    assign ready_o = init_q && (state_q == StAcc) && !full;
    assign accept  = valid_i && ready_o;
    assign valid_o = (count_q != '0);
    assign pop     = valid_o && ready_i;
    assign err_o   = err_q;

    assign {data_o, addr_o, last_o, blk_size_o} = mem_q[rd_ptr_q];

    // Mask the code to size_i bits and splice it in behind the current fill
    always_comb begin
        code_mask = ~({OUT_W{1'b1}} >> size_i);
        code_m    = code_top & code_mask;
        wide      = {acc_q, {OUT_W{1'b0}}} | ({code_m, {OUT_W{1'b0}}} >> fill_q);
        new_fill  = fill_q + FILL_W'(size_i);
        rem_fill  = new_fill - FILL_W'(OUT_W);
        bsum      = {1'b0, bcnt_q} + (BLK_W + 1)'(size_i);
        bovf      = bsum[BLK_W];
        bsat      = bovf ? {BLK_W{1'b1}} : bsum[BLK_W-1:0];
        // Bits that left in full words; the remainder stays in the accumulator
        emitted   = bovf ? {BLK_W{1'b1}} : (bsum[BLK_W-1:0] - BLK_W'(rem_fill));
    end

    // Next-state and push decision for the packer
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        fill_d    = fill_q;
        wcnt_d    = wcnt_q;
        bcnt_d    = bcnt_q;
        err_d     = err_q;
        push      = 1'b0;
        push_data = wide[2*OUT_W-1:OUT_W];
        push_addr = wcnt_q;
        push_last = 1'b0;
        push_blk  = '0;

        if (state_q == StAcc && accept) begin
            if (size_i > SIZE_W'(MAX_CODE)) begin
                // Oversized code: dropped, state untouched
                err_d = 1'b1;
            end else begin
                if (sop_i && (wcnt_q != '0 || fill_q != FILL_W'(PREFIX_W))) begin
                    err_d = 1'b1;
                end
                if (bovf) begin
                    err_d = 1'b1;
                end
                if (eop_i && new_fill <= FILL_W'(OUT_W)) begin
                    push      = 1'b1;
                    push_last = 1'b1;
                    push_blk  = bsat;
                    acc_d     = ACC_INIT;
                    fill_d    = FILL_W'(PREFIX_W);
                    wcnt_d    = '0;
                    bcnt_d    = BLK_W'(PREFIX_W);
                end else if (new_fill >= FILL_W'(OUT_W)) begin
                    push     = 1'b1;
                    push_blk = emitted;
                    if (wcnt_q == {ADDR_W{1'b1}}) begin
                        err_d = 1'b1;
                    end
                    acc_d  = wide[OUT_W-1:0];
                    fill_d = rem_fill;
                    wcnt_d = wcnt_q + 1'b1;
                    bcnt_d = bsat;
                    if (eop_i) begin
                        state_d = StFlush;
                    end
                end else begin
                    acc_d  = wide[2*OUT_W-1:OUT_W];
                    fill_d = new_fill;
                    bcnt_d = bsat;
                end
            end
        end else if (state_q == StFlush && !full) begin
            push      = 1'b1;
            push_data = acc_q;
            push_last = 1'b1;
            push_blk  = bcnt_q;
            acc_d     = ACC_INIT;
            fill_d    = FILL_W'(PREFIX_W);
            wcnt_d    = '0;
            bcnt_d    = BLK_W'(PREFIX_W);
            state_d   = StAcc;
        end
    end

    // Packer FSM and accumulator registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StAcc;
            acc_q   <= ACC_INIT;
            fill_q  <= FILL_W'(PREFIX_W);
            wcnt_q  <= '0;
            bcnt_q  <= BLK_W'(PREFIX_W);
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            fill_q  <= fill_d;
            wcnt_q  <= wcnt_d;
            bcnt_q  <= bcnt_d;
            err_q   <= err_d;
        end
    end

    // Holds ready_o low until the first clock after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_q <= 1'b0;
        end else begin
            init_q <= 1'b1;
        end
    end

    // Output FIFO; a same-cycle push and pop leave occupancy unchanged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= {push_data, push_addr, push_last, push_blk};
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule
